// File: rtl/uart_rx_fifo_less.sv
// uart_rx_fifo_less: 8N1 serial receiver with 16x oversampling, 3-sample
// majority voting and a single-entry valid/ready holding register.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for rxs to go low
// START  | validating the start bit at its mid-bit decision
// DATA   | shifting in 8 data bits, LSB first
// STOP   | checking the stop bit; good stop hands the byte to the holder
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_fifo_less #(
    parameter int sysclk_frequency = 1250,
    parameter int baud             = 115200
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);
    localparam int SAMPLE_DIV_RAW = (sysclk_frequency * 100000) / (baud * 16);
    localparam int SAMPLE_DIV     = (SAMPLE_DIV_RAW < 1) ? 1 : SAMPLE_DIV_RAW;
    localparam int PRESC_W        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
    } state_t;

    state_t state_q, state_d;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         tick_q, tick_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               samp7_q, samp7_d;
    logic               samp8_q, samp8_d;
    logic [7:0]         shift_q, shift_d;
    logic               load_q, load_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               framing_q, framing_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic       rxs;
    logic       in_frame;
    logic       strobe;
    logic [7:0] tick_now;
    logic       decision;
    logic       maj;

    // Sampling strobes, mid-bit decision point and majority vote.
    always_comb begin
        rxs      = sync2_q;
        in_frame = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
        strobe   = (presc_q == PRESC_W'(SAMPLE_DIV - 1));
        tick_now = tick_q + 8'd1;
        // Bit index in the upper nibble must agree with the decision count.
        decision = strobe && in_frame && (tick_now[3:0] == 4'd9) && (tick_now[7:4] == bit_cnt_q);
        maj      = (samp7_q & samp8_q) | (samp7_q & rxs) | (samp8_q & rxs);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rxs) state_d = ST_START;
            ST_START: if (decision) state_d = maj ? ST_IDLE : ST_DATA;
            ST_DATA:  if (decision && (bit_cnt_q == 4'd8)) state_d = ST_STOP;
            ST_STOP:  if (decision) state_d = maj ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values: timing, shifting, holding register.
    always_comb begin
        sync1_d   = rxd;
        sync2_d   = sync1_q;
        presc_d   = (!in_frame || strobe) ? '0 : presc_q + PRESC_W'(1);
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        samp7_d   = samp7_q;
        samp8_d   = samp8_q;
        shift_d   = shift_q;
        if (!in_frame) begin
            tick_d    = 8'd0;
            bit_cnt_d = 4'd0;
        end else if (strobe) begin
            tick_d = tick_now;
            if (tick_now[3:0] == 4'd7) samp7_d = rxs;
            if (tick_now[3:0] == 4'd8) samp8_d = rxs;
            if (decision) bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if ((state_q == ST_DATA) && decision) shift_d = {maj, shift_q[7:1]};
        load_d    = (state_q == ST_STOP) && decision && maj;
        framing_d = (state_q == ST_STOP) && decision && !maj;
        busy_d    = (state_q != ST_IDLE);

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (load_q) begin
            // A full holder only takes the new byte if it is drained this cycle.
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Datapath registers; reset abandons any frame in progress silently.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            presc_q    <= '0;
            tick_q     <= 8'd0;
            bit_cnt_q  <= 4'd0;
            samp7_q    <= 1'b0;
            samp8_q    <= 1'b0;
            shift_q    <= 8'd0;
            load_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            framing_q  <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            samp7_q    <= samp7_d;
            samp8_q    <= samp8_d;
            shift_q    <= shift_d;
            load_q     <= load_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            framing_q  <= framing_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule
